// File: rtl/ps2_kbd_tx_pkg.sv
// Shared definitions for the PS/2 keyboard transmitter: frame layout,
// FSM state encoding and frame bit helpers.
package ps2_kbd_tx_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame position idx: 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
        if (idx == 4'd0)
            return 1'b0;
        else if (idx <= 4'd8)
            return d[3'(idx - 4'd1)];
        else if (idx == 4'd9)
            return odd_parity(d);
        else
            return 1'b1;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_fifo.sv
// Synchronous scan-code FIFO; a push is accepted while full when a pop
// happens in the same cycle, so the count stays at DEPTH.
module ps2_fifo
    import ps2_kbd_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: queues scan codes and serialises
// each one as an 11-bit frame on open-drain clock/data lines.
module ps2_kbd_tx
    import ps2_kbd_tx_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int GAP   = 2000,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_stb,
    output logic       full,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       ovf,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int DIV_W = $clog2(3 * DIV);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int CW    = (DIV_W > GAP_W) ? DIV_W : GAP_W;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    ps2_state_t             state;
    logic [CW-1:0]          cnt;
    logic [3:0]             idx;
    logic [7:0]             cur_byte;
    logic [7:0]             fifo_dout;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   phase_end;
    logic                   pop;

    assign phase_end = (cnt == DIV_LAST);
    assign pop       = (state == ST_HIGH) && phase_end && (idx == LAST_BIT);
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    ps2_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_stb),
        .pop   (pop),
        .din   (data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The entry stays in the FIFO until its stop bit completes, so an
    // inhibited frame is simply retried from the same head entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            cur_byte   <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_abort   <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            ovf      <= data_stb && full && !pop;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && ps2_clk_i) begin
                        state      <= ST_SETUP;
                        cnt        <= '0;
                        idx        <= '0;
                        cur_byte   <= fifo_dout;
                        ps2_dat_oe <= ~frame_bit(fifo_dout, 4'd0);
                    end
                end
                ST_SETUP: begin
                    if (!phase_end) begin
                        cnt <= cnt + 1'b1;
                    end else if (idx != LAST_BIT && !ps2_clk_i) begin
                        state      <= ST_GAP;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_abort   <= 1'b1;
                    end else begin
                        state      <= ST_LOW;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (!phase_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        state      <= ST_HIGH;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (!phase_end) begin
                        cnt <= cnt + 1'b1;
                    end else if (idx == LAST_BIT) begin
                        state      <= ST_GAP;
                        cnt        <= '0;
                        ps2_dat_oe <= 1'b0;
                        tx_done    <= 1'b1;
                    end else if (!ps2_clk_i) begin
                        state      <= ST_GAP;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_abort   <= 1'b1;
                    end else begin
                        state      <= ST_SETUP;
                        cnt        <= '0;
                        idx        <= idx + 4'd1;
                        ps2_dat_oe <= ~frame_bit(cur_byte, idx + 4'd1);
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a host-side PS/2 receiver model
// decodes frames and compares them against a queue of expected frames.
module tb_ps2_kbd_tx;

    localparam int DIV       = 4;
    localparam int GAP       = 8;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 33 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       data_stb = 1'b0;
    logic       host_hold = 1'b0;
    logic       full, busy, tx_done, tx_abort, ovf;
    logic       ps2_clk_i, ps2_clk_oe, ps2_dat_oe;

    assign ps2_clk_i = ~(ps2_clk_oe | host_hold);

    ps2_kbd_tx #(
        .DIV   (DIV),
        .GAP   (GAP),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_stb   (data_stb),
        .full       (full),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_abort   (tx_abort),
        .ovf        (ovf),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [10:0] expq[$];
    logic [10:0] rx_hist[$];
    logic [10:0] rx_frame = '0;
    int          rx_cnt = 0;
    int          frames_rx = 0;
    int          done_cnt = 0;
    int          abort_cnt = 0;
    int          ovf_cnt = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    int          min_gap = 1000;
    bit          in_frame = 0;
    bit          have_done = 0;
    bit          prev_line = 1;
    bit          prev_dat = 0;

    function automatic logic [10:0] build_frame(input logic [7:0] b);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++)
            if (b[i]) ones++;
        p = ((ones % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit accept);
        data     = b;
        data_stb = 1'b1;
        if (accept)
            expq.push_back(build_frame(b));
        @(posedge clk);
        #1;
        data_stb = 1'b0;
    endtask

    task automatic waitIdle(input int maxc, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, busy, 1'b0);
    endtask

    task automatic waitRx(input int target, input int maxc, input string tag);
        int n;
        n = 0;
        while (rx_cnt != target && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, rx_cnt, target);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Host receiver model: samples the data line on each falling PS/2 clock
    // edge and tracks frame timing, gaps and status pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_cnt    = 0;
                in_frame  = 0;
                have_done = 0;
                prev_line = 1;
                prev_dat  = 0;
            end else begin
                if (!in_frame && ps2_dat_oe === 1'b1 && !prev_dat) begin
                    in_frame  = 1;
                    start_cyc = cyc;
                    if (have_done && (cyc - done_cyc) < min_gap)
                        min_gap = cyc - done_cyc;
                end
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    checkOutput("frame_len", cyc - start_cyc, FRAME_CYC);
                    in_frame  = 0;
                    have_done = 1;
                    done_cyc  = cyc;
                end
                if (tx_abort === 1'b1) begin
                    abort_cnt++;
                    in_frame  = 0;
                    have_done = 0;
                end
                if (ovf === 1'b1)
                    ovf_cnt++;
                if (host_hold) begin
                    rx_cnt = 0;
                end else if (prev_line && ps2_clk_oe === 1'b1) begin
                    rx_frame[4'(rx_cnt)] = ~ps2_dat_oe;
                    rx_cnt++;
                    if (rx_cnt == 11) begin
                        frames_rx++;
                        rx_hist.push_back(rx_frame);
                        checkOutput("rx_expected", expq.size() != 0, 1'b1);
                        if (expq.size() != 0)
                            checkOutput("rx_frame", rx_frame, expq.pop_front());
                        rx_cnt = 0;
                    end
                end
                prev_line = (ps2_clk_oe !== 1'b1);
                prev_dat  = (ps2_dat_oe === 1'b1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_full",     full,       1'b0);
        checkOutput("rst_busy",     busy,       1'b0);
        checkOutput("rst_tx_done",  tx_done,    1'b0);
        checkOutput("rst_tx_abort", tx_abort,   1'b0);
        checkOutput("rst_ovf",      ovf,        1'b0);
        checkOutput("rst_clk_oe",   ps2_clk_oe, 1'b0);
        checkOutput("rst_dat_oe",   ps2_dat_oe, 1'b0);

        $display("[TB] single frame 0x76");
        applyStimulus(8'h76, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("start_dat_oe", ps2_dat_oe, 1'b1);
        checkOutput("start_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("start_busy",   busy,       1'b1);
        waitIdle(400, "idle_76");
        checkOutput("done_76",   done_cnt,   1);
        checkOutput("frames_76", frames_rx,  1);
        checkOutput("bits_76",   rx_hist[0], 11'h4EC);
        checkOutput("abort_76",  abort_cnt,  0);

        $display("[TB] back-to-back F0 76");
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h76, 1'b1);
        waitIdle(800, "idle_f076");
        checkOutput("done_f076", done_cnt,   3);
        checkOutput("bits_f0",   rx_hist[1], 11'h7E0);
        checkOutput("bits_76b",  rx_hist[2], 11'h4EC);
        checkOutput("gap_ok",    (min_gap >= GAP) && (min_gap < 2 * GAP), 1'b1);

        $display("[TB] host inhibit during bit 4");
        applyStimulus(8'h76, 1'b1);
        waitRx(5, 500, "rx_bit4");
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("bit4_high", ps2_clk_oe, 1'b0);
        host_hold = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("abort_cnt",    abort_cnt,  1);
        checkOutput("abort_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("abort_dat_oe", ps2_dat_oe, 1'b0);
        checkOutput("abort_busy",   busy,       1'b1);
        checkOutput("abort_nodone", done_cnt,   3);
        host_hold = 1'b0;
        waitIdle(600, "idle_retry");
        checkOutput("retry_done",   done_cnt,   4);
        checkOutput("retry_frames", frames_rx,  4);
        checkOutput("retry_bits",   rx_hist[3], 11'h4EC);
        checkOutput("retry_abort",  abort_cnt,  1);

        $display("[TB] overflow burst");
        for (int i = 0; i < 6; i++)
            applyStimulus(8'(8'h11 * (i + 1)), i < DEPTH);
        checkOutput("burst_full", full, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("burst_ovf", ovf_cnt, 2);
        while (cyc < start_cyc + FRAME_CYC - 1) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(8'h77, 1'b1);
        checkOutput("pushpop_full", full, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("pushpop_ovf",  ovf_cnt,  2);
        checkOutput("pushpop_done", done_cnt, 5);
        waitIdle(2000, "idle_burst");
        checkOutput("burst_done",   done_cnt,  9);
        checkOutput("burst_frames", frames_rx, 9);
        checkOutput("burst_empty",  full,      1'b0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h76, 1'b1);
        waitRx(6, 500, "rx_bit5");
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_clk_oe", ps2_clk_oe, 1'b0);
        checkOutput("midrst_dat_oe", ps2_dat_oe, 1'b0);
        checkOutput("midrst_busy",   busy,       1'b0);
        checkOutput("midrst_full",   full,       1'b0);
        void'(expq.pop_back());
        rst = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        checkOutput("midrst_nodone", done_cnt,    9);
        checkOutput("midrst_idle",   busy,        1'b0);
        checkOutput("expq_drained",  expq.size(), 0);
        checkOutput("frames_total",  frames_rx,   9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
